// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the SDRAM host-port arbiter.
// The FSM state encoding lives here so the arbiter and its bench agree on names.
package sdram_arb_pkg;

   localparam int DEF_HADDR_WIDTH = 24;
   localparam int WORD_WIDTH      = 16;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_ACC,
      WAIT_DONE,
      DONE
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Circular priority encoder: first set request at or after ptr, wrapping modulo N.
// Purely combinational; works for non-power-of-two N.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);

   logic [IW:0] cand;

   // Walk offsets from the far end so the nearest hit to ptr is written last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int k = N - 1; k >= 0; k--) begin
         cand = {1'b0, ptr} + (IW + 1)'(k);
         if (cand >= (IW + 1)'(N)) begin
            cand = cand - (IW + 1)'(N);
         end
         if (req[cand[IW-1:0]]) begin
            found = 1'b1;
            idx   = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter multiplexing several requesters onto one SDRAM controller
// host port; re-issues enables the controller drops while initialising or refreshing.
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int NUM_PORTS   = 4,
   parameter int HADDR_WIDTH = DEF_HADDR_WIDTH,
   parameter int ACC_TIMEOUT = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_PORTS-1:0]             req_valid,
   input  logic [NUM_PORTS-1:0]             req_we,
   input  logic [NUM_PORTS*HADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_PORTS*WORD_WIDTH-1:0]  req_wdata,
   output logic [NUM_PORTS-1:0]             req_done,
   output logic [WORD_WIDTH-1:0]            rd_data,
   output logic [NUM_PORTS-1:0]             grant,
   output logic [7:0]                       retry_cnt,
   output logic [HADDR_WIDTH-1:0]           haddr,
   output logic [WORD_WIDTH-1:0]            data_input,
   output logic                             rd_enable,
   output logic                             wr_enable,
   input  logic [WORD_WIDTH-1:0]            data_output,
   input  logic                             busy
);

   localparam int IW = $clog2(NUM_PORTS);
   localparam int CW = $clog2(ACC_TIMEOUT + 1);

   arb_state_t    state_reg;
   logic [IW-1:0] ptr_reg;
   logic [IW-1:0] idx_reg;
   logic          we_reg;
   logic [CW-1:0] wait_cnt_reg;

   logic          pick_found;
   logic [IW-1:0] pick_idx;

   rr_pick #(
      .N  (NUM_PORTS),
      .IW (IW)
   ) u_pick (
      .req   (req_valid),
      .ptr   (ptr_reg),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // Enables are raised on entry to ISSUE so they are high for exactly that cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= IDLE;
         ptr_reg      <= '0;
         idx_reg      <= '0;
         we_reg       <= 1'b0;
         wait_cnt_reg <= '0;
         req_done     <= '0;
         rd_data      <= '0;
         grant        <= '0;
         retry_cnt    <= '0;
         haddr        <= '0;
         data_input   <= '0;
         rd_enable    <= 1'b0;
         wr_enable    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (pick_found) begin
                  idx_reg    <= pick_idx;
                  we_reg     <= req_we[pick_idx];
                  haddr      <= req_addr[int'(pick_idx)*HADDR_WIDTH +: HADDR_WIDTH];
                  data_input <= req_wdata[int'(pick_idx)*WORD_WIDTH +: WORD_WIDTH];
                  grant      <= NUM_PORTS'(1) << pick_idx;
                  rd_enable  <= ~req_we[pick_idx];
                  wr_enable  <= req_we[pick_idx];
                  state_reg  <= ISSUE;
               end
            end
            ISSUE: begin
               rd_enable    <= 1'b0;
               wr_enable    <= 1'b0;
               wait_cnt_reg <= '0;
               state_reg    <= WAIT_ACC;
            end
            WAIT_ACC: begin
               if (busy) begin
                  state_reg <= WAIT_DONE;
               end else if (wait_cnt_reg == CW'(ACC_TIMEOUT - 1)) begin
                  // Controller never went busy: the enable was swallowed, try again.
                  if (retry_cnt != 8'hFF) begin
                     retry_cnt <= retry_cnt + 8'd1;
                  end
                  rd_enable <= ~we_reg;
                  wr_enable <= we_reg;
                  state_reg <= ISSUE;
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + CW'(1);
               end
            end
            WAIT_DONE: begin
               if (!busy) begin
                  if (!we_reg) begin
                     rd_data <= data_output;
                  end
                  req_done  <= grant;
                  state_reg <= DONE;
               end
            end
            DONE: begin
               req_done  <= '0;
               grant     <= '0;
               ptr_reg   <= (idx_reg == IW'(NUM_PORTS - 1)) ? '0 : idx_reg + IW'(1);
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Round-robin arbiter sharing the single-word SDRAM controller host interface (haddr/data_input/data_output/busy/rd_enable/wr_enable) between NUM_PORTS requesters.
- Locks a grant per transaction, issues a one-cycle enable pulse, and confirms acceptance via busy.
- Re-issues commands the controller drops during init or refresh.
- Returns read data and a per-port done pulse; sits between client masters and the controller.

Parameters:
- NUM_PORTS, 4, number of requesters (2..8)
- HADDR_WIDTH, 24, host word-address width (bank+row+col)
- ACC_TIMEOUT, 3, cycles in WAIT_ACC without busy before re-issue

Ports:
- clk  in  1  single clock, shared with controller
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_PORTS  per-port request; held with payload until done
- req_we  in  NUM_PORTS  1=write, 0=read
- req_addr  in  NUM_PORTS*HADDR_WIDTH  packed addresses, port i at [i*HADDR_WIDTH +: HADDR_WIDTH]
- req_wdata  in  NUM_PORTS*16  packed write data
- req_done  out  NUM_PORTS  one-cycle completion pulse to the granted port
- rd_data  out  16  read data, valid in the req_done cycle of a read
- grant  out  NUM_PORTS  one-hot current owner, 0 in IDLE
- retry_cnt  out  8  saturating count of re-issues since reset
- haddr  out  HADDR_WIDTH  to controller
- data_input  out  16  to controller
- rd_enable  out  1  to controller
- wr_enable  out  1  to controller
- data_output  in  16  from controller
- busy  in  1  from controller

Behaviour:
- Reset (async, immediate): state=IDLE; pointer=0; all outputs 0; retry_cnt=0. An in-flight transaction is abandoned with no req_done.
- Controller contract:
  - Enable is sampled only while the controller is idle; otherwise it is silently dropped.
  - An accepted enable sampled at edge T gives busy=1 first visible after edge T+2.
  - When busy returns to 0, data_output holds the read word.
  - The controller is ready again immediately after busy falls.
- FSM (all outputs registered):
  - IDLE: if any req_valid, pick the first set bit searching circularly from pointer. Latch port index, we, addr and wdata into haddr/data_input. Set grant. Go to ISSUE.
  - ISSUE: one cycle, rd_enable=~we or wr_enable=we. Clear wait counter. Go to WAIT_ACC.
  - WAIT_ACC: enables 0. On busy=1 go to WAIT_DONE. After ACC_TIMEOUT cycles with busy=0, increment retry_cnt (saturate at 255) and go to ISSUE.
  - WAIT_DONE: stay while busy=1. On busy=0, capture data_output into rd_data and go to DONE.
  - DONE: req_done[idx]=1 for one cycle. pointer=idx+1 mod NUM_PORTS. grant=0. Go to IDLE.
- Enables are never high for more than one consecutive cycle; haddr/data_input are stable from ISSUE through WAIT_DONE.
- Minimum transaction (no drop) = IDLE→ISSUE→WAIT_ACC(2)→WAIT_DONE(n)→DONE; back-to-back grants cost one IDLE cycle.
- Simultaneous requests are resolved purely by pointer order. A port with req_valid in its own DONE cycle competes normally in the next IDLE and is not favoured.
- req_valid dropped mid-transaction: the transaction still completes and req_done still pulses.
- rd_data is held until the next read completes; on writes it is unchanged.
- idx width = $clog2(NUM_PORTS); pointer wrap-around is explicit modulo NUM_PORTS (non-power-of-two allowed).

Decomposition:
- sdram_arb_pkg: FSM state enum (IDLE, ISSUE, WAIT_ACC, WAIT_DONE, DONE), default HADDR_WIDTH, word width 16.
- Sub-module rr_pick: combinational circular priority encoder (req vector, pointer → found, index). All sequencing stays in sdram_arbiter.

Test Plan:
- Port0 write addr 0x012345 data 0xBEEF; model busy high 2 cycles after enable for 4 cycles → wr_enable one pulse, haddr=0x012345, data_input=0xBEEF, req_done[0] pulses, grant back to 0.
- Port2 read addr 0x000010; model returns 0xA5A5 when busy falls → rd_data=0xA5A5 in req_done[2] cycle; retry_cnt=0.
- Ports 0..3 all request at once, held continuously → grants 0,1,2,3,0 in order, exactly one done per grant.
- Model drops the first two enables (refresh, busy stays 0) → re-issue after 3 idle cycles each, third accepted, retry_cnt=2, single req_done.
- rst asserted in WAIT_DONE → outputs 0 at once, no req_done; after release, pending port1 is granted first (pointer=0, port0 idle).
- Port3 done while port3 and port1 requesting (pointer→0) → port1 granted next, then port3.
